if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues requests to instruction memory, and loads the IF/ID pipeline register.
- Consumes the `if_pc_source` decision from the ID-stage control decoder, together with branch and jump targets.
- Produces the instruction word whose opcode field feeds that decoder.
- Tolerates multi-cycle memory through a req/ready handshake, with a one-entry skid buffer for stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_pc_source  in  2  00 = PC+4, 01 = branch_addr, 10 = jump_addr, 11 = reserved (treated as 00).
- branch_addr  in  32  branch target from ID.
- jump_addr  in  32  jump target from ID.
- stall  in  1  hazard unit: hold PC and IF/ID.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to the PC.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction.
- if_id_instr  out  32  IF/ID instruction register.
- if_id_pc_plus4  out  32  IF/ID PC+4 register.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n = 0):
  - pc = RESET_PC, state = FETCH, skid empty.
  - if_id_instr = NOP_INSTR, if_id_pc_plus4 = 0, if_id_valid = 0.
- Outputs: imem_addr = pc, combinational. imem_req = 1 in FETCH and WAIT_REDIR, 0 in HOLD.
- Handshake: a transfer completes when imem_req && imem_ready. imem_addr must stay stable from request until completion.
- Redirect event: if_pc_source ∈ {01,10}. The target's low 2 bits are forced to 0.
- Redirect has priority over stall.
- PC+4 arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

FETCH:
- Complete, no redirect, stall = 0:
  - IF/ID <= {imem_rdata, pc+4, 1}; pc <= pc+4.
  - 1-cycle throughput when ready is held high.
- Complete, no redirect, stall = 1:
  - skid <= {imem_rdata, pc+4}; pc <= pc+4; IF/ID holds; go to HOLD.
- Complete with redirect:
  - Discard the word; pc <= target; IF/ID <= bubble (NOP_INSTR, valid 0); stay in FETCH.
- Not complete, redirect:
  - Latch target into pend_pc; IF/ID <= bubble; go to WAIT_REDIR.
  - pc is not changed, so the address stays stable.
- Not complete, no redirect:
  - stall = 0: IF/ID <= bubble.
  - stall = 1: IF/ID holds.

WAIT_REDIR:
- On completion: discard the word; pc <= pend_pc; go to FETCH.
- IF/ID <= bubble every cycle; stall is ignored.
- A further redirect overwrites pend_pc (latest wins).

HOLD:
- stall = 1, no redirect: everything holds; imem_req = 0.
- stall = 0, no redirect: IF/ID <= {skid, 1}; go to FETCH.
- Redirect: discard skid; pc <= target; IF/ID <= bubble; go to FETCH.

Other rules:
- Reset asserted mid-transfer abandons the request; the memory must accept the address change after reset.
- if_pc_source = 11 never redirects.
- The correctness of stall during a redirect is guaranteed upstream; the block still obeys the redirect-priority rule.

Decomposition:
- Shared package mips_pkg:
  - PC_SRC_NEXT = 2'b00, PC_SRC_BRANCH = 2'b01, PC_SRC_JUMP = 2'b10.
  - NOP_INSTR.
  - Fetch-state encoding: FETCH, WAIT_REDIR, HOLD.
- Sub-module if_id_reg: IF/ID register with load/bubble/hold controls, async active-low reset. Reused by the flush logic of later stages.

Test Plan:
- Reset release, imem_ready = 1 constant, rdata = addr-tagged → addresses 0,4,8 on consecutive cycles; IF/ID valid from cycle 1; if_id_pc_plus4 = 4,8,12.
- imem_ready low 3 cycles at pc = 8 → imem_addr stays 8, IF/ID gets 3 bubbles, then the instruction at 8 with pc_plus4 = 12.
- if_pc_source = 01, branch_addr = 0x40, ready = 1 → next imem_addr = 0x40; the in-flight word is dropped (valid 0 one cycle).
- Jump (10, jump_addr = 0x103) while waiting at pc = 0x20 → address held at 0x20 until ready; word dropped; next address 0x100.
- stall = 1 for 2 cycles while a fetch completes at pc = 0x10 → imem_req drops; IF/ID unchanged; on release IF/ID = word@0x10 with pc_plus4 = 0x14; next fetch at 0x14.
- Branch during HOLD, and rst_n pulsed low mid-wait → skid dropped and pc = target; async reset gives pc = RESET_PC and valid = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: PC-source encoding, bubble word and fetch FSM states.
// Used by the fetch stage and by any later stage that needs to recognise a bubble.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH      = 2'b00,
    WAIT_REDIR = 2'b01,
    HOLD       = 2'b10
  } fetch_state_e;

  function automatic logic is_redirect(input logic [1:0] src);
    return (src == PC_SRC_BRANCH) || (src == PC_SRC_JUMP);
  endfunction

  // Targets are word addresses; the low two bits are dropped.
  function automatic logic [XLEN-1:0] redirect_target(input logic [1:0]      src,
                                                      input logic [XLEN-1:0] br,
                                                      input logic [XLEN-1:0] jmp);
    logic [XLEN-1:0] t;
    t = (src == PC_SRC_JUMP) ? jmp : br;
    return t & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with bubble (highest priority), load and hold controls.
// A bubble also clears pc_plus4 so a flushed slot looks exactly like the reset slot.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble_i) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc_plus4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the imem req/ready bus and loads IF/ID.
// A one-entry skid holds a word that completed while the hazard unit stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        if_pc_source,
  input  logic [31:0]       branch_addr,
  input  logic [31:0]       jump_addr,
  input  logic              stall,
  if_stage_if.master        imem,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_plus4,
  output logic              if_id_valid
);
  import mips_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;

  logic         redirect, complete;
  logic [31:0]  target, pc_plus4;
  logic         ld, bub;
  logic [31:0]  reg_instr, reg_pc4;

  assign redirect = is_redirect(if_pc_source);
  assign target   = redirect_target(if_pc_source, branch_addr, jump_addr);
  assign pc_plus4 = pc_q + 32'd4;

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q != HOLD);
  assign complete       = imem.imem_req && imem.imem_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ld           = 1'b0;
    bub          = 1'b0;
    reg_instr    = imem.imem_rdata;
    reg_pc4      = pc_plus4;

    case (state_q)
      FETCH: begin
        if (complete) begin
          if (redirect) begin
            pc_d = target;
            bub  = 1'b1;
          end else if (!stall) begin
            ld   = 1'b1;
            pc_d = pc_plus4;
          end else begin
            skid_instr_d = imem.imem_rdata;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          // pc must stay put until the outstanding request completes
          pend_d  = target;
          bub     = 1'b1;
          state_d = WAIT_REDIR;
        end else if (!stall) begin
          bub = 1'b1;
        end
      end

      WAIT_REDIR: begin
        bub = 1'b1;
        if (redirect) pend_d = target;
        if (complete) begin
          pc_d    = redirect ? target : pend_q;
          state_d = FETCH;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          bub     = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          ld        = 1'b1;
          reg_instr = skid_instr_q;
          reg_pc4   = skid_pc4_q;
          state_d   = FETCH;
        end
      end

      default: begin
        bub     = 1'b1;
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      pend_q       <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld),
    .bubble_i   (bub),
    .instr_i    (reg_instr),
    .pc_plus4_i (reg_pc4),
    .instr_o    (if_id_instr),
    .pc_plus4_o (if_id_pc_plus4),
    .valid_o    (if_id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns {16'hC0DE, addr[15:0]} for every address.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  src;
  logic [31:0] br_addr;
  logic [31:0] jmp_addr;
  logic        stall;
  logic        ready;
  logic [31:0] instr, pc4;
  logic        valid;

  int errors = 0;
  int checks = 0;
  logic [97:0] exp;

  if_stage_if bus ();

  assign bus.imem_ready = ready;
  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc_source   (src),
    .branch_addr    (br_addr),
    .jump_addr      (jmp_addr),
    .stall          (stall),
    .imem           (bus),
    .if_id_instr    (instr),
    .if_id_pc_plus4 (pc4),
    .if_id_valid    (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {req, addr, valid, instr, pc_plus4}
  function automatic logic [97:0] snap();
    return {bus.imem_req, bus.imem_addr, valid, instr, pc4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    src = 2'b00; stall = 1'b0; ready = 1'b1;
    br_addr = 32'h0; jmp_addr = 32'h0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; src = 2'b00; stall = 1'b0; ready = 1'b1;
    br_addr = 32'h0; jmp_addr = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL reset_state got=%h exp=%h", snap(), exp); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    tick(); exp = {1'b1, 32'h4, 1'b1, 32'hC0DE0000, 32'h4};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL seq_c1 got=%h exp=%h", snap(), exp); end
    tick(); exp = {1'b1, 32'h8, 1'b1, 32'hC0DE0004, 32'h8};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL seq_c2 got=%h exp=%h", snap(), exp); end
    tick(); exp = {1'b1, 32'hC, 1'b1, 32'hC0DE0008, 32'hC};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL seq_c3 got=%h exp=%h", snap(), exp); end
  endtask

  task automatic test_ready_low();
    apply_reset();
    tick(); tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); exp = {1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
      checks++; if (snap() !== exp) begin errors++; $display("FAIL wait_bubble%0d got=%h exp=%h", i, snap(), exp); end
    end
    ready = 1'b1;
    tick(); exp = {1'b1, 32'hC, 1'b1, 32'hC0DE0008, 32'hC};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL wait_done got=%h exp=%h", snap(), exp); end
  endtask

  task automatic test_branch();
    apply_reset();
    tick(); exp = {1'b1, 32'h4, 1'b1, 32'hC0DE0000, 32'h4};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL br_pre got=%h exp=%h", snap(), exp); end
    src = 2'b01; br_addr = 32'h40;
    tick(); exp = {1'b1, 32'h40, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL br_drop got=%h exp=%h", snap(), exp); end
    src = 2'b00;
    tick(); exp = {1'b1, 32'h44, 1'b1, 32'hC0DE0040, 32'h44};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL br_target got=%h exp=%h", snap(), exp); end
  endtask

  task automatic test_jump_wait();
    apply_reset();
    tick();
    src = 2'b01; br_addr = 32'h20;
    tick(); exp = {1'b1, 32'h20, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL jw_at20 got=%h exp=%h", snap(), exp); end
    src = 2'b10; jmp_addr = 32'h103; ready = 1'b0;
    tick(); exp = {1'b1, 32'h20, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL jw_hold1 got=%h exp=%h", snap(), exp); end
    src = 2'b00;
    tick(); exp = {1'b1, 32'h20, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL jw_hold2 got=%h exp=%h", snap(), exp); end
    ready = 1'b1;
    tick(); exp = {1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL jw_redir got=%h exp=%h", snap(), exp); end
    tick(); exp = {1'b1, 32'h104, 1'b1, 32'hC0DE0100, 32'h104};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL jw_target got=%h exp=%h", snap(), exp); end
  endtask

  task automatic test_latest_wins();
    apply_reset();
    ready = 1'b0; src = 2'b10; jmp_addr = 32'h200;
    tick(); exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL lw_wait1 got=%h exp=%h", snap(), exp); end
    src = 2'b01; br_addr = 32'h67; stall = 1'b1;
    tick(); exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL lw_wait2 got=%h exp=%h", snap(), exp); end
    src = 2'b00; stall = 1'b0; ready = 1'b1;
    tick(); exp = {1'b1, 32'h64, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL lw_redir got=%h exp=%h", snap(), exp); end
    tick(); exp = {1'b1, 32'h68, 1'b1, 32'hC0DE0064, 32'h68};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL lw_target got=%h exp=%h", snap(), exp); end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1;
    tick(); exp = {1'b0, 32'h14, 1'b1, 32'hC0DE000C, 32'h10};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL st_c1 got=%h exp=%h", snap(), exp); end
    tick();
    checks++; if (snap() !== exp) begin errors++; $display("FAIL st_c2 got=%h exp=%h", snap(), exp); end
    stall = 1'b0;
    tick(); exp = {1'b1, 32'h14, 1'b1, 32'hC0DE0010, 32'h14};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL st_release got=%h exp=%h", snap(), exp); end
    tick(); exp = {1'b1, 32'h18, 1'b1, 32'hC0DE0014, 32'h18};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL st_next got=%h exp=%h", snap(), exp); end
  endtask

  task automatic test_hold_branch_reset();
    apply_reset();
    tick(); tick();
    stall = 1'b1;
    tick(); exp = {1'b0, 32'hC, 1'b1, 32'hC0DE0004, 32'h8};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL hb_hold got=%h exp=%h", snap(), exp); end
    src = 2'b01; br_addr = 32'h80;
    tick(); exp = {1'b1, 32'h80, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL hb_branch got=%h exp=%h", snap(), exp); end
    src = 2'b00; stall = 1'b0; ready = 1'b0;
    tick(); exp = {1'b1, 32'h80, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL hb_wait got=%h exp=%h", snap(), exp); end
    #2 rst_n = 1'b0;
    #1 exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL hb_async_rst got=%h exp=%h", snap(), exp); end
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    tick(); exp = {1'b1, 32'h4, 1'b1, 32'hC0DE0000, 32'h4};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL hb_after_rst got=%h exp=%h", snap(), exp); end
  endtask

  task automatic test_wrap_reserved();
    apply_reset();
    tick();
    src = 2'b11; jmp_addr = 32'h200; br_addr = 32'h300;
    tick(); exp = {1'b1, 32'h8, 1'b1, 32'hC0DE0004, 32'h8};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL wr_reserved got=%h exp=%h", snap(), exp); end
    src = 2'b01; br_addr = 32'hFFFF_FFFF;
    tick(); exp = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL wr_mask got=%h exp=%h", snap(), exp); end
    src = 2'b00;
    tick(); exp = {1'b1, 32'h0, 1'b1, 32'hC0DEFFFC, 32'h0};
    checks++; if (snap() !== exp) begin errors++; $display("FAIL wr_wrap got=%h exp=%h", snap(), exp); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ready_low();
    test_branch();
    test_jump_wait();
    test_latest_wins();
    test_stall();
    test_hold_branch_reset();
    test_wrap_reserved();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
